// File: rtl/pa_clic_int_pkg.sv
// Shared constants and types for the CLIC external interrupt conditioning stage.
// This package defines the line count, the synchronizer and filter defaults, and the filter mode.
package pa_clic_int_pkg;

    localparam int CLIC_INTNUM       = 144;
    localparam int CLIC_LOCAL_INTNUM = 16;
    localparam int EXT_INTNUM        = CLIC_INTNUM - CLIC_LOCAL_INTNUM;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int FILT_CYC_DEF    = 4;
    localparam int FILT_CYC_MAX    = 8;

    // The counter is sized for the longest legal filter window.
    // FILT_CYC can then be changed without touching the width.
    function automatic int calc_cnt_w(input int max_cyc);
        return (max_cyc <= 2) ? 1 : $clog2(max_cyc);
    endfunction

    localparam int CNT_W_DEF = calc_cnt_w(FILT_CYC_MAX);

    typedef enum logic {
        FILT_BYPASS = 1'b0,
        FILT_ACTIVE = 1'b1
    } filt_mode_e;

endpackage

// File: rtl/pa_clic_int_filt_bit.sv
// One interrupt line: a multi-flop synchronizer, a stability filter, the vld flop
// and the previous-cycle vld flop used to detect a rising edge.
module pa_clic_int_filt_bit
    import pa_clic_int_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int FILT_CYC    = FILT_CYC_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic       forever_cpuclk,
    input  logic       clic_rst_b,
    input  logic       i_raw,
    input  filt_mode_e i_mode,
    output logic       o_vld,
    output logic       o_rise
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYC - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   r_vld;
    logic                   r_vld_q;
    logic                   w_vld_nxt;
    logic                   w_sync_out;
    logic                   w_diff;

    assign w_sync_out = r_sync[SYNC_STAGES-1];
    assign w_diff     = w_sync_out ^ r_vld;

    always_ff @(posedge forever_cpuclk or negedge clic_rst_b) begin
        if (!clic_rst_b) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
        end
    end

    // Any sample equal to the current vld restarts the window, so short pulses are dropped.
    // The >= compare keeps the counter from ever wrapping.
    always_comb begin
        w_vld_nxt = r_vld;
        w_cnt_nxt = '0;
        if (i_mode == FILT_BYPASS) begin
            w_vld_nxt = w_sync_out;
        end else if (w_diff) begin
            if (r_cnt >= CNT_LAST) begin
                w_vld_nxt = w_sync_out;
            end else begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge forever_cpuclk or negedge clic_rst_b) begin
        if (!clic_rst_b) begin
            r_cnt   <= '0;
            r_vld   <= 1'b0;
            r_vld_q <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_vld   <= w_vld_nxt;
            r_vld_q <= r_vld;
        end
    end

    assign o_vld  = r_vld;
    assign o_rise = r_vld & ~r_vld_q;

endmodule

// File: rtl/pa_clic_int_sync.sv
// Conditions the asynchronous pad interrupt lines for the CLIC top.
// Each line is synchronized and filtered, and a newly asserted line raises a wakeup pulse.
module pa_clic_int_sync
    import pa_clic_int_pkg::*;
#(
    parameter int INTNUM      = EXT_INTNUM,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int FILT_CYC    = FILT_CYC_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic              forever_cpuclk,
    input  logic              clic_rst_b,
    input  logic [INTNUM-1:0] pad_clic_int_raw,
    input  logic              clic_int_filt_en,
    input  logic              pad_yy_scan_mode,
    output logic [INTNUM-1:0] pad_clic_int_vld,
    output logic              clic_int_wakeup
);

    filt_mode_e        w_mode;
    logic [INTNUM-1:0] w_rise;
    logic              r_wakeup;

    // Scan mode must see a plain pipeline, so it overrides the filter enable.
    assign w_mode = (clic_int_filt_en & ~pad_yy_scan_mode) ? FILT_ACTIVE : FILT_BYPASS;

    for (genvar g = 0; g < INTNUM; g++) begin : g_line
        pa_clic_int_filt_bit #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_CYC    (FILT_CYC),
            .CNT_W       (CNT_W)
        ) u_filt_bit (
            .forever_cpuclk (forever_cpuclk),
            .clic_rst_b     (clic_rst_b),
            .i_raw          (pad_clic_int_raw[g]),
            .i_mode         (w_mode),
            .o_vld          (pad_clic_int_vld[g]),
            .o_rise         (w_rise[g])
        );
    end

    always_ff @(posedge forever_cpuclk or negedge clic_rst_b) begin
        if (!clic_rst_b) begin
            r_wakeup <= 1'b0;
        end else begin
            r_wakeup <= |w_rise;
        end
    end

    assign clic_int_wakeup = r_wakeup;

endmodule

// File: tb/tb_pa_clic_int_sync.sv
// Directed bench for pa_clic_int_sync: a table of per-cycle vectors plus a
// hand-written sequence for asynchronous reset in the middle of a count.
module tb_pa_clic_int_sync;

    localparam int N = 128;

    typedef struct {
        string        name;
        int           step;
        logic         rst;
        logic [N-1:0] raw;
        logic         filtEn;
        logic         scan;
        logic [N-1:0] expVld;
        logic         expWake;
    } vec_t;

    logic         forever_cpuclk = 1'b0;
    logic         clic_rst_b = 1'b0;
    logic [N-1:0] pad_clic_int_raw = '0;
    logic         clic_int_filt_en = 1'b1;
    logic         pad_yy_scan_mode = 1'b0;
    logic [N-1:0] pad_clic_int_vld;
    logic         clic_int_wakeup;

    int checks = 0;
    int failures = 0;
    vec_t tbl[$];

    pa_clic_int_sync u_dut (
        .forever_cpuclk   (forever_cpuclk),
        .clic_rst_b       (clic_rst_b),
        .pad_clic_int_raw (pad_clic_int_raw),
        .clic_int_filt_en (clic_int_filt_en),
        .pad_yy_scan_mode (pad_yy_scan_mode),
        .pad_clic_int_vld (pad_clic_int_vld),
        .clic_int_wakeup  (clic_int_wakeup)
    );

    always #5 forever_cpuclk = ~forever_cpuclk;

    function automatic logic [N-1:0] bitOf(input int idx);
        logic [N-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    task automatic addVec(input string name, input int step, input logic rst,
                          input logic [N-1:0] raw, input logic fe, input logic sc,
                          input logic [N-1:0] ev, input logic ew);
        vec_t v;
        v.name = name; v.step = step; v.rst = rst; v.raw = raw;
        v.filtEn = fe; v.scan = sc; v.expVld = ev; v.expWake = ew;
        tbl.push_back(v);
    endtask

    task automatic checkOutput(input string name, input int step,
                               input logic [N-1:0] expVld, input logic expWake);
        checks++;
        if (pad_clic_int_vld !== expVld) begin
            failures++;
            $display("[TB] FAIL %s_vld step %0d got %h want %h", name, step, pad_clic_int_vld, expVld);
        end
        checks++;
        if (clic_int_wakeup !== expWake) begin
            failures++;
            $display("[TB] FAIL %s_wake step %0d got %b want %b", name, step, clic_int_wakeup, expWake);
        end
    endtask

    task automatic resetDut(input string name);
        @(negedge forever_cpuclk);
        clic_rst_b = 1'b0;
        pad_clic_int_raw = '0;
        #1;
        checkOutput({name, "_rst"}, 0, '0, 1'b0);
        repeat (2) @(posedge forever_cpuclk);
        @(negedge forever_cpuclk);
        clic_rst_b = 1'b1;
    endtask

    task automatic applyStimulus(input vec_t v);
        pad_clic_int_raw = v.raw;
        clic_int_filt_en = v.filtEn;
        pad_yy_scan_mode = v.scan;
        @(posedge forever_cpuclk);
        #1;
    endtask

    initial begin
        logic [N-1:0] m;
        logic [N-1:0] both;
        int r0 [0:18];
        int v0 [0:18];

        // Filtered rise on raw[5], then symmetric filtered fall with no wakeup.
        for (int k = 1; k <= 15; k++)
            addVec("filtRise5", k, k == 1, (k <= 8) ? bitOf(5) : '0, 1'b1, 1'b0,
                   (k >= 6 && k <= 13) ? bitOf(5) : '0, k == 7);

        // Two-cycle glitch on raw[9] is dropped; a later steady level still needs the full window.
        for (int k = 1; k <= 14; k++)
            addVec("glitch9", k, k == 1, (k <= 2 || k >= 6) ? bitOf(9) : '0, 1'b1, 1'b0,
                   (k >= 11) ? bitOf(9) : '0, k == 12);

        // Bypass: raw[0] toggles every 4 cycles; vld is raw delayed by two steps.
        r0[0] = 0;
        v0[0] = 0;
        for (int k = 1; k <= 18; k++) begin
            r0[k] = (k <= 16 && (((k - 1) / 4) % 2) == 0) ? 1 : 0;
            v0[k] = (k >= 3) ? r0[k-2] : 0;
        end
        for (int k = 1; k <= 18; k++)
            addVec("bypass0", k, k == 1, r0[k] != 0 ? bitOf(0) : '0, 1'b0, 1'b0,
                   v0[k] != 0 ? bitOf(0) : '0,
                   (k >= 2) ? (v0[k-1] != 0 && v0[k-2] == 0) : 1'b0);

        // Three lines rising together give one wakeup pulse.
        m = bitOf(3) | bitOf(64) | bitOf(127);
        for (int k = 1; k <= 9; k++)
            addVec("multi", k, k == 1, m, 1'b1, 1'b0, (k >= 6) ? m : '0, k == 7);

        // Filter disabled after two sampled cycles of raw[7]: vld follows on that edge.
        for (int k = 1; k <= 7; k++)
            addVec("modeSw7", k, k == 1, bitOf(7), k <= 4, 1'b0,
                   (k >= 5) ? bitOf(7) : '0, k == 6);

        // Scan mode forces bypass latency even with the filter enabled.
        for (int k = 1; k <= 5; k++)
            addVec("scan2", k, k == 1, bitOf(2), 1'b1, 1'b1,
                   (k >= 3) ? bitOf(2) : '0, k == 4);

        // Rises on consecutive cycles give back-to-back wakeup pulses.
        for (int k = 1; k <= 6; k++)
            addVec("b2b", k, k == 1, (k == 1) ? bitOf(1) : (bitOf(1) | bitOf(2)), 1'b0, 1'b0,
                   (k == 3) ? bitOf(1) : ((k >= 4) ? (bitOf(1) | bitOf(2)) : '0),
                   k == 4 || k == 5);

        $display("[TB] running %0d table vectors", tbl.size());
        for (int i = 0; i < tbl.size(); i++) begin
            clic_int_filt_en = tbl[i].filtEn;
            pad_yy_scan_mode = tbl[i].scan;
            if (tbl[i].rst)
                resetDut(tbl[i].name);
            applyStimulus(tbl[i]);
            checkOutput(tbl[i].name, tbl[i].step, tbl[i].expVld, tbl[i].expWake);
        end

        // Asynchronous reset while vld[20] is high and raw[21] is mid-count.
        clic_int_filt_en = 1'b1;
        pad_yy_scan_mode = 1'b0;
        resetDut("midRst");
        pad_clic_int_raw = bitOf(20);
        repeat (6) @(posedge forever_cpuclk);
        #1;
        checkOutput("midRstPre", 6, bitOf(20), 1'b0);
        both = bitOf(20) | bitOf(21);
        pad_clic_int_raw = both;
        repeat (3) @(posedge forever_cpuclk);
        #3;
        clic_rst_b = 1'b0;
        #1;
        checkOutput("midRstAsync", 0, '0, 1'b0);
        repeat (2) @(posedge forever_cpuclk);
        @(negedge forever_cpuclk);
        clic_rst_b = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge forever_cpuclk);
            #1;
            checkOutput("midRstPost", k, (k >= 6) ? both : '0, k == 7);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
